// File: rtl/soc_trace_fifo.sv
// Bus-trace capture FIFO: records RAM-address and CP0 exception-address changes for host drain.
// Optional per-entry cycle timestamps are enabled with the TRACE_TIMESTAMP_EN macro.
module soc_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   ram_addr,
  input  logic [31:0]   ram_data,
  input  logic [31:0]   cp0_exc_addr,
  input  logic          trace_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic          out_exc,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [15:0]   drop_cnt
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]   out_ts
`endif
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  function automatic logic [15:0] sat_add_drop(input logic [15:0] cur, input logic [1:0] n);
    logic [16:0] sum;
    sum = {1'b0, cur} + {15'b0, n};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [31:0] r_mem_addr [DEPTH];
  logic [31:0] r_mem_data [DEPTH];
  logic        r_mem_exc  [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] r_mem_ts   [DEPTH];
  logic [31:0] r_ts;
`endif
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_drop;
  logic [31:0]   r_prev_addr, r_prev_exc;
  logic          r_primed;

  logic          w_exc_chg, w_addr_chg, w_req, w_push, w_pop, w_full, w_empty;
  logic          w_coll_drop, w_full_drop;
  logic [1:0]    w_drop_n;
  logic [31:0]   w_ent_addr, w_ent_data;

  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_exc_chg  = (cp0_exc_addr != r_prev_exc);
  assign w_addr_chg = (ram_addr != r_prev_addr);
  assign w_req      = r_primed && trace_en && (w_exc_chg || w_addr_chg);
  assign w_pop      = !w_empty && out_ready;
  assign w_push     = w_req && (!w_full || w_pop);

  // An exception change pre-empts a simultaneous address change; the latter is counted as lost.
  assign w_coll_drop = w_req && w_exc_chg && w_addr_chg;
  assign w_full_drop = w_req && w_full && !w_pop;
  assign w_drop_n    = {1'b0, w_coll_drop} + {1'b0, w_full_drop};
  assign w_ent_addr  = w_exc_chg ? cp0_exc_addr : ram_addr;
  assign w_ent_data  = w_exc_chg ? ram_addr     : ram_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_drop      <= '0;
      r_prev_addr <= '0;
      r_prev_exc  <= '0;
      r_primed    <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      r_ts        <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
        r_mem_exc[i]  <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
        r_mem_ts[i]   <= '0;
`endif
      end
    end else begin
      // History tracks the bus even while capture is disabled, so enabling never fakes a change.
      r_prev_addr <= ram_addr;
      r_prev_exc  <= cp0_exc_addr;
      r_primed    <= 1'b1;
`ifdef TRACE_TIMESTAMP_EN
      r_ts        <= r_ts + 32'd1;
`endif
      if (w_push) begin
        r_mem_addr[r_wptr] <= w_ent_addr;
        r_mem_data[r_wptr] <= w_ent_data;
        r_mem_exc[r_wptr]  <= w_exc_chg;
`ifdef TRACE_TIMESTAMP_EN
        r_mem_ts[r_wptr]   <= r_ts;
`endif
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_drop <= sat_add_drop(r_drop, w_drop_n);
    end
  end

  assign out_valid = !w_empty;
  assign out_addr  = w_empty ? 32'd0 : r_mem_addr[r_rptr];
  assign out_data  = w_empty ? 32'd0 : r_mem_data[r_rptr];
  assign out_exc   = w_empty ? 1'b0  : r_mem_exc[r_rptr];
`ifdef TRACE_TIMESTAMP_EN
  assign out_ts    = w_empty ? 32'd0 : r_mem_ts[r_rptr];
`endif
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_soc_trace_fifo.sv
// Self-checking bench for soc_trace_fifo: fixed vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_soc_trace_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk;
  logic        rst, en, rdy;
  logic [31:0] ra, rd, ce;
  logic        o_valid, o_exc, o_full, o_empty;
  logic [31:0] o_addr, o_data;
  logic [AW:0] o_count;
  logic [15:0] o_drop;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] o_ts;
`endif

  soc_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(rst), .ram_addr(ra), .ram_data(rd), .cp0_exc_addr(ce),
    .trace_en(en), .out_valid(o_valid), .out_ready(rdy), .out_addr(o_addr),
    .out_data(o_data), .out_exc(o_exc), .count(o_count), .full(o_full),
    .empty(o_empty), .drop_cnt(o_drop)
`ifdef TRACE_TIMESTAMP_EN
    , .out_ts(o_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of captured entries plus the history of the bus.
  typedef struct { logic [31:0] a; logic [31:0] d; logic e; logic [31:0] t; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_prev_a, m_prev_e;
  bit          m_primed;
  int          m_drop;
  logic [31:0] m_cyc;

  function automatic void model_edge();
    ent_t nx;
    bit   pop, req, ec, ac;
    int   lost;
    if (rst) begin
      mq.delete();
      m_prev_a = 0; m_prev_e = 0; m_primed = 0; m_drop = 0; m_cyc = 0;
      return;
    end
    lost = 0;
    pop = (mq.size() > 0) && rdy;
    ec  = (ce != m_prev_e);
    ac  = (ra != m_prev_a);
    req = m_primed && en && (ec || ac);
    if (pop) void'(mq.pop_front());
    if (req) begin
      nx.a = ec ? ce : ra;
      nx.d = ec ? ra : rd;
      nx.e = ec;
      nx.t = m_cyc;
      if (ec && ac) lost++;
      if (mq.size() < DEPTH) mq.push_back(nx);
      else lost++;
    end
    m_drop   = (m_drop + lost > 65535) ? 65535 : m_drop + lost;
    m_prev_a = ra;
    m_prev_e = ce;
    m_primed = 1;
    m_cyc    = m_cyc + 1;
  endfunction

  task automatic step(input logic r, input logic e, input logic y,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] c);
    rst = r; en = e; rdy = y; ra = a; rd = d; ce = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(o_count), 32'(n));
    chk({tag, ".empty"}, 32'(o_empty), 32'(n == 0));
    chk({tag, ".full"},  32'(o_full),  32'(n == DEPTH));
    chk({tag, ".valid"}, 32'(o_valid), 32'(n != 0));
    chk({tag, ".addr"},  o_addr, (n != 0) ? mq[0].a : 32'd0);
    chk({tag, ".data"},  o_data, (n != 0) ? mq[0].d : 32'd0);
    chk({tag, ".exc"},   32'(o_exc), (n != 0) ? 32'(mq[0].e) : 32'd0);
    chk({tag, ".drop"},  32'(o_drop), 32'(m_drop));
`ifdef TRACE_TIMESTAMP_EN
    chk({tag, ".ts"},    o_ts, (n != 0) ? mq[0].t : 32'd0);
`endif
  endtask

  typedef struct {
    logic rst, en, rdy;
    logic [31:0] ra, rd, ce;
    int cnt; logic vld; logic [31:0] oa, od; logic oe; int drop;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic y, logic [31:0] a, logic [31:0] d,
                              logic [31:0] c, int cnt, logic v, logic [31:0] oa,
                              logic [31:0] od, logic oe, int drop);
    vec_t x;
    x.rst = r; x.en = e; x.rdy = y; x.ra = a; x.rd = d; x.ce = c;
    x.cnt = cnt; x.vld = v; x.oa = oa; x.od = od; x.oe = oe; x.drop = drop;
    return x;
  endfunction

  vec_t vt[11];

  initial begin
    rst = 1; en = 0; rdy = 0; ra = 0; rd = 0; ce = 0;

    vt[0]  = mk(1, 0, 0, 32'h0,        32'h0,        32'h0, 0, 0, 32'h0,        32'h0,        0, 0);
    vt[1]  = mk(0, 1, 0, 32'h00400000, 32'h0,        32'h0, 0, 0, 32'h0,        32'h0,        0, 0);
    vt[2]  = mk(0, 1, 0, 32'h00400000, 32'h0,        32'h0, 0, 0, 32'h0,        32'h0,        0, 0);
    vt[3]  = mk(0, 1, 0, 32'h00400000, 32'h0,        32'h0, 0, 0, 32'h0,        32'h0,        0, 0);
    vt[4]  = mk(0, 1, 0, 32'h00400004, 32'h12345678, 32'h0, 1, 1, 32'h00400004, 32'h12345678, 0, 0);
    vt[5]  = mk(0, 1, 0, 32'h00400004, 32'h12345678, 32'h0, 1, 1, 32'h00400004, 32'h12345678, 0, 0);
    vt[6]  = mk(0, 1, 0, 32'h00400008, 32'h0000AAAA, 32'h4, 2, 1, 32'h00400004, 32'h12345678, 0, 1);
    vt[7]  = mk(0, 1, 1, 32'h00400008, 32'h0000AAAA, 32'h4, 1, 1, 32'h00000004, 32'h00400008, 1, 1);
    vt[8]  = mk(0, 1, 1, 32'h00400008, 32'h0000AAAA, 32'h4, 0, 0, 32'h0,        32'h0,        0, 1);
    vt[9]  = mk(0, 0, 0, 32'h00500000, 32'h0000BBBB, 32'h4, 0, 0, 32'h0,        32'h0,        0, 1);
    vt[10] = mk(0, 1, 0, 32'h00500000, 32'h0000BBBB, 32'h4, 0, 0, 32'h0,        32'h0,        0, 1);

    for (int i = 0; i < 11; i++) begin
      step(vt[i].rst, vt[i].en, vt[i].rdy, vt[i].ra, vt[i].rd, vt[i].ce);
      chk($sformatf("vec%0d.count", i), 32'(o_count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d.valid", i), 32'(o_valid), 32'(vt[i].vld));
      chk($sformatf("vec%0d.addr", i),  o_addr, vt[i].oa);
      chk($sformatf("vec%0d.data", i),  o_data, vt[i].od);
      chk($sformatf("vec%0d.exc", i),   32'(o_exc), 32'(vt[i].oe));
      chk($sformatf("vec%0d.drop", i),  32'(o_drop), 32'(vt[i].drop));
      chk($sformatf("vec%0d.empty", i), 32'(o_empty), 32'(vt[i].cnt == 0));
    end

    // Overflow: 17 distinct addresses with the consumer stalled.
    step(1, 0, 0, 32'h0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h1000, 32'h0, 32'h0);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 32'h1004 + 32'(4 * i), 32'hD000 + 32'(i), 32'h0);
    chk("ovf.full",  32'(o_full), 32'd1);
    chk("ovf.count", 32'(o_count), 32'd16);
    chk("ovf.drop",  32'(o_drop), 32'd1);
    chk("ovf.head",  o_addr, 32'h1004);
    check_model("ovf");

    // Full FIFO with simultaneous pop and push.
    step(0, 1, 1, 32'h2000, 32'hBEEF, 32'h0);
    chk("fpp.count", 32'(o_count), 32'd16);
    chk("fpp.drop",  32'(o_drop), 32'd1);
    chk("fpp.head",  o_addr, 32'h1008);
    for (int i = 0; i < 15; i++) step(0, 1, 1, 32'h2000, 32'hBEEF, 32'h0);
    chk("fpp.tail_addr",  o_addr, 32'h2000);
    chk("fpp.tail_data",  o_data, 32'hBEEF);
    chk("fpp.tail_count", 32'(o_count), 32'd1);
    step(0, 1, 1, 32'h2000, 32'hBEEF, 32'h0);
    check_model("drain");

    // Reset mid-operation with 5 stored entries.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h3000 + 32'(4 * i), 32'h0, 32'h0);
    chk("rmo.pre_count", 32'(o_count), 32'd5);
    step(1, 1, 0, 32'h3010, 32'h0, 32'h0);
    chk("rmo.count", 32'(o_count), 32'd0);
    chk("rmo.empty", 32'(o_empty), 32'd1);
    chk("rmo.drop",  32'(o_drop), 32'd0);
    chk("rmo.addr",  o_addr, 32'd0);
    step(0, 1, 0, 32'h3100, 32'h0, 32'h0);
    chk("rmo.first_ignored", 32'(o_count), 32'd0);
    step(0, 1, 0, 32'h3104, 32'h77, 32'h0);
    chk("rmo.next_captured", o_addr, 32'h3104);
    check_model("rmo");

`ifdef TRACE_TIMESTAMP_EN
    begin
      logic [31:0] t0;
      step(1, 0, 0, 32'h0, 32'h0, 32'h0);
      step(0, 1, 0, 32'h0, 32'h0, 32'h0);
      step(0, 1, 0, 32'h4000, 32'h0, 32'h0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 32'h4000, 32'h0, 32'h0);
      step(0, 1, 0, 32'h4004, 32'h0, 32'h0);
      t0 = o_ts;
      step(0, 1, 1, 32'h4004, 32'h0, 32'h0);
      chk("ts.delta", o_ts - t0, 32'd7);
      step(0, 1, 1, 32'h4004, 32'h0, 32'h0);
      chk("ts.empty_zero", o_ts, 32'd0);
    end
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic        r, e, y;
      logic [31:0] a, c;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 7) != 0);
      y = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      a = 32'h100 + 32'(4 * $urandom_range(0, 3));
      c = ($urandom_range(0, 15) == 0) ? 32'(4 * $urandom_range(0, 3)) : ce;
      step(r, e, y, a, $urandom, c);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
